// File: rtl/vector_elem_sequencer.sv
// vector_elem_sequencer
//   Breaks one vector instruction into per-register micro-ops. The block
//   captures the vector configuration on start, then walks the register group
//   one register per accepted micro-op. Each micro-op carries the register
//   numbers and a byte enable that covers the active elements.
//
//   Build option: when VECTOR_SEQ_SKIP_EMPTY_EN is defined, only registers
//   that hold active elements are issued, and vl=0 goes straight to FINISH.
//   Otherwise the whole group (2^vlmul registers) is always issued, and tail
//   registers carry byte_en=0.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start                      request a sequence (ignored while busy)
//   vl, vsew, vlmul            vector length, element width code, group size code
//   vd/vs1/vs2_base            base register numbers of the groups
//   uop_ready                  datapath accepts the presented micro-op
//   busy                       sequence in progress (ISSUE or FINISH)
//   uop_valid                  micro-op presented
//   vd/vs1/vs2_addr            per-uop register numbers
//   byte_en                    active bytes within the 32-bit register
//   uop_first, uop_last        first / last micro-op of the sequence
//   done                       one-cycle completion pulse
//   cfg_err                    one-cycle pulse (with done) on reserved vsew
module vector_elem_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] vl,
   input  logic [1:0] vsew,
   input  logic [1:0] vlmul,
   input  logic [4:0] vd_base,
   input  logic [4:0] vs1_base,
   input  logic [4:0] vs2_base,
   input  logic       uop_ready,
   output logic       busy,
   output logic       uop_valid,
   output logic [4:0] vd_addr,
   output logic [4:0] vs1_addr,
   output logic [4:0] vs2_addr,
   output logic [3:0] byte_en,
   output logic       uop_first,
   output logic       uop_last,
   output logic       done,
   output logic       cfg_err
);

`ifdef VECTOR_SEQ_SKIP_EMPTY_EN
   localparam bit SKIP_EMPTY = 1'b1;
`else
   localparam bit SKIP_EMPTY = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

   typedef struct packed {
      logic [4:0] vd;
      logic [4:0] vs1;
      logic [4:0] vs2;
      logic [3:0] be;
      logic       first;
      logic       last;
   } uop_t;

   state_t     state;
   logic [2:0] k;
   logic [4:0] vl_q;
   logic [1:0] vsew_q;
   logic [1:0] vlmul_q;
   logic [4:0] vd_q;
   logic [4:0] vs1_q;
   logic [4:0] vs2_q;
   uop_t       nxt_uop;

   function automatic logic [2:0] elems_per_reg(input logic [1:0] sew);
      case (sew)
         2'd0:    return 3'd4;
         2'd1:    return 3'd2;
         default: return 3'd1;
      endcase
   endfunction

   // Number of micro-ops in the sequence for this configuration.
   function automatic logic [3:0] uop_count(input logic [4:0] len,
                                            input logic [1:0] sew,
                                            input logic [1:0] mul);
      logic [3:0] regs;
      logic [5:0] needed;
      regs = 4'd1 << mul;
      // ceil(len / elems_per_reg); elems_per_reg is a power of two
      case (sew)
         2'd0:    needed = ({1'b0, len} + 6'd3) >> 2;
         2'd1:    needed = ({1'b0, len} + 6'd1) >> 1;
         default: needed = {1'b0, len};
      endcase
      // a vl larger than the group still issues no more than the group
      if (SKIP_EMPTY && (needed < {2'b00, regs}))
         return needed[3:0];
      return regs;
   endfunction

   function automatic uop_t make_uop(input logic [2:0] idx,
                                     input logic [4:0] len,
                                     input logic [1:0] sew,
                                     input logic [1:0] mul,
                                     input logic [4:0] bvd,
                                     input logic [4:0] bvs1,
                                     input logic [4:0] bvs2);
      uop_t       u;
      logic [2:0] epr;
      logic [3:0] n;
      logic [5:0] elems_before;
      logic [5:0] rem;
      epr          = elems_per_reg(sew);
      n            = uop_count(len, sew, mul);
      elems_before = {3'b000, idx} * {3'b000, epr};
      u.vd         = bvd  + {2'b00, idx};
      u.vs1        = bvs1 + {2'b00, idx};
      u.vs2        = bvs2 + {2'b00, idx};
      u.first      = (idx == 3'd0);
      u.last       = ({1'b0, idx} == (n - 4'd1));
      // rem is only formed when positive, so no signed arithmetic is needed
      if ({1'b0, len} <= elems_before) begin
         u.be = '0;
      end else begin
         rem = {1'b0, len} - elems_before;
         if (rem >= {3'b000, epr})
            u.be = '1;
         else if (sew == 2'd0)
            u.be = (4'd1 << rem) - 4'd1;
         else if (sew == 2'd1)
            u.be = 4'b0011;
         else
            u.be = '0;
      end
      return u;
   endfunction

   // In IDLE the first uop is built from the live inputs so it can be
   // registered on the same edge that captures the configuration.
   always_comb begin
      nxt_uop = '0;
      if (state == IDLE)
         nxt_uop = make_uop(3'd0, vl, vsew, vlmul, vd_base, vs1_base, vs2_base);
      else
         nxt_uop = make_uop(k + 3'd1, vl_q, vsew_q, vlmul_q, vd_q, vs1_q, vs2_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         k         <= '0;
         vl_q      <= '0;
         vsew_q    <= '0;
         vlmul_q   <= '0;
         vd_q      <= '0;
         vs1_q     <= '0;
         vs2_q     <= '0;
         busy      <= 1'b0;
         uop_valid <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         {vd_addr, vs1_addr, vs2_addr, byte_en, uop_first, uop_last} <= '0;
      end else begin
         case (state)
            IDLE: begin
               done    <= 1'b0;
               cfg_err <= 1'b0;
               if (start) begin
                  vl_q    <= vl;
                  vsew_q  <= vsew;
                  vlmul_q <= vlmul;
                  vd_q    <= vd_base;
                  vs1_q   <= vs1_base;
                  vs2_q   <= vs2_base;
                  k       <= '0;
                  busy    <= 1'b1;
                  if (vsew == 2'd3) begin
                     state   <= FINISH;
                     done    <= 1'b1;
                     cfg_err <= 1'b1;
                  end else if (SKIP_EMPTY && (vl == 5'd0)) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state     <= ISSUE;
                     uop_valid <= 1'b1;
                     {vd_addr, vs1_addr, vs2_addr, byte_en, uop_first, uop_last} <= nxt_uop;
                  end
               end
            end
            ISSUE: begin
               if (uop_ready) begin
                  if (uop_last) begin
                     state     <= FINISH;
                     done      <= 1'b1;
                     uop_valid <= 1'b0;
                     {vd_addr, vs1_addr, vs2_addr, byte_en, uop_first, uop_last} <= '0;
                  end else begin
                     k <= k + 3'd1;
                     {vd_addr, vs1_addr, vs2_addr, byte_en, uop_first, uop_last} <= nxt_uop;
                  end
               end
            end
            FINISH: begin
               state   <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
               cfg_err <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
